// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module   : load_store_unit_if
// Brief    : CPU request/response and data-memory signals of the load/store unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface load_store_unit_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // slave: the load/store unit itself
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  // master: the CPU and data memory around it
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-request data-memory initiator; sub-word loads, RMW sub-word stores.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int ADDR_W = 6
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  load_store_unit_if.slave  bus
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_WRITE  = 2'd2;
  localparam logic [1:0] c_RESP   = 2'd3;

  logic [1:0]        r_state;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_req_err;
  logic              w_sw;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  assign w_accept = bus.req_valid && (r_state == c_IDLE);
  assign w_sw     = r_we && (r_f3 == 3'd2);

  // Alignment and funct3 legality, judged on the live request at accept time
  always_comb begin
    w_req_err = 1'b0;
    if (bus.req_we) begin
      case (bus.req_funct3)
        3'd0:    w_req_err = 1'b0;
        3'd1:    w_req_err = bus.req_addr[0];
        3'd2:    w_req_err = (bus.req_addr[1:0] != 2'b00);
        default: w_req_err = 1'b1;
      endcase
    end else begin
      case (bus.req_funct3)
        3'd0, 3'd4: w_req_err = 1'b0;
        3'd1, 3'd5: w_req_err = bus.req_addr[0];
        3'd2:       w_req_err = (bus.req_addr[1:0] != 2'b00);
        default:    w_req_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0: w_byte = bus.mem_rdata[7:0];
      2'd1: w_byte = bus.mem_rdata[15:8];
      2'd2: w_byte = bus.mem_rdata[23:16];
      2'd3: w_byte = bus.mem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_f3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {24'h000000, w_byte};
      3'd5:    w_load = {16'h0000, w_half};
      default: w_load = bus.mem_rdata;
    endcase
  end

  // Read-modify-write: only the addressed lane takes the store data
  always_comb begin
    w_merged = bus.mem_rdata;
    if (r_f3 == 3'd0) begin
      case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = bus.mem_rdata;
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_merge <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_f3    <= bus.req_funct3;
            r_addr  <= bus.req_addr[ADDR_W+1:0];
            r_wdata <= bus.req_wdata;
            if (w_req_err) begin
              r_rdata <= 32'h0;
              r_err   <= 1'b1;
              r_state <= c_RESP;
            end else begin
              r_state <= c_ACCESS;
            end
          end
        end
        c_ACCESS: begin
          r_err <= 1'b0;
          if (!r_we) begin
            r_rdata <= w_load;
            r_state <= c_RESP;
          end else if (w_sw) begin
            r_rdata <= 32'h0;
            r_state <= c_RESP;
          end else begin
            r_merge <= w_merged;
            r_state <= c_WRITE;
          end
        end
        c_WRITE: begin
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
          r_state <= c_RESP;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == c_IDLE);
  assign bus.resp_valid = (r_state == c_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.mem_read   = (r_state == c_ACCESS);
  assign bus.mem_write  = ((r_state == c_ACCESS) && w_sw) || (r_state == c_WRITE);
  assign bus.mem_addr   = r_addr[ADDR_W+1:2];
  assign bus.mem_wdata  = ((r_state == c_ACCESS) && w_sw) ? r_wdata :
                          (r_state == c_WRITE)            ? r_merge : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a word-addressed memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int ADDR_W = 6;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n_rd;
    int          n_wr;
    logic [31:0] wdata;
    int          acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   n_resp;
  int   rd_cnt;
  int   wr_cnt;
  logic [31:0] last_wdata;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  exp_t sb_q[$];

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: memory activity per transaction, responses popped from the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (bus.mem_read)  rd_cnt++;
      if (bus.mem_write) begin
        wr_cnt++;
        last_wdata = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        n_resp++;
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
          check("latency", cyc - e.acc_cyc, e.lat);
          check("mem_read_cycles", rd_cnt, e.n_rd);
          check("mem_write_cycles", wr_cnt, e.n_wr);
          if (e.n_wr == 1) check("mem_wdata", last_wdata, e.wdata);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Presents a request, waits for acceptance and logs the expected response
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic [31:0] exp_wdata,
                      input bit hold, input bit push);
    exp_t e;
    int   waited;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
      e.rdata   = exp_rdata;
      e.err     = exp_err;
      e.lat     = exp_err ? 0 : ((we && f3 != 3'd2) ? 2 : 1);
      e.n_rd    = exp_err ? 0 : 1;
      e.n_wr    = (exp_err || !we) ? 0 : 1;
      e.wdata   = exp_wdata;
      e.acc_cyc = cyc;
      if (push) sb_q.push_back(e);
    end
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int resp_before;
    n_checks = 0; n_errors = 0; n_resp = 0;
    rd_cnt = 0; wr_cnt = 0; last_wdata = 32'h0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h01010101 * i;
    mem[2] = 32'hAA22CC33;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready",      {31'd0, bus.req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata,          32'd0);
    check("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
    check("rst_mem_read",   {31'd0, bus.mem_read},   32'd0);
    check("rst_mem_write",  {31'd0, bus.mem_write},  32'd0);
    check("rst_mem_addr",   {26'd0, bus.mem_addr},   32'd0);
    check("rst_mem_wdata",  bus.mem_wdata,           32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Loads of word 2 in every width
    send(0, 3'd2, 32'h08, 0, 32'hAA22CC33, 0, 0, 0, 1);
    send(0, 3'd0, 32'h0B, 0, 32'hFFFFFFAA, 0, 0, 0, 1);
    send(0, 3'd4, 32'h0B, 0, 32'h000000AA, 0, 0, 0, 1);
    send(0, 3'd1, 32'h08, 0, 32'hFFFFCC33, 0, 0, 0, 1);
    send(0, 3'd5, 32'h0A, 0, 32'h0000AA22, 0, 0, 0, 1);
    send(0, 3'd0, 32'h09, 0, 32'hFFFFFFCC, 0, 0, 0, 1);
    send(0, 3'd4, 32'h08, 0, 32'h00000033, 0, 0, 0, 1);
    drain();

    // Sub-word stores by read-modify-write, then restore with sw
    send(1, 3'd0, 32'h09, 32'h12345677, 0, 0, 32'hAA227733, 0, 1);
    send(0, 3'd2, 32'h08, 0, 32'hAA227733, 0, 0, 0, 1);
    send(1, 3'd1, 32'h0A, 32'h0000BEEF, 0, 0, 32'hBEEF7733, 0, 1);
    send(0, 3'd2, 32'h08, 0, 32'hBEEF7733, 0, 0, 0, 1);
    send(1, 3'd2, 32'h08, 32'hAA22CC33, 0, 0, 32'hAA22CC33, 0, 1);
    drain();
    check("word2_restored", mem[2], 32'hAA22CC33);

    // Misaligned and illegal requests
    send(0, 3'd2, 32'h06, 0, 0, 1, 0, 0, 1);
    send(1, 3'd1, 32'h03, 32'hFFFF, 0, 1, 0, 0, 1);
    send(0, 3'd3, 32'h00, 0, 0, 1, 0, 0, 1);
    send(1, 3'd3, 32'h00, 0, 0, 1, 0, 0, 1);
    drain();

    // Reset while the sh is in its write cycle
    send(1, 3'd1, 32'h08, 32'h00005A5A, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("rmw_write_phase", {31'd0, bus.mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_write", {31'd0, bus.mem_write}, 32'd0);
    check("rst_mid_ready",   {31'd0, bus.req_ready}, 32'd1);
    check("rst_mid_valid",   {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("word2_untouched", mem[2], 32'hAA22CC33);
    send(0, 3'd2, 32'h08, 0, 32'hAA22CC33, 0, 0, 0, 1);
    drain();

    // Back-to-back with req_valid held, including aliased addresses
    resp_before = n_resp;
    send(0, 3'd2, 32'h108, 0, 32'hAA22CC33, 0, 0, 1, 1);
    send(0, 3'd1, 32'h10A, 0, 32'hFFFFAA22, 0, 0, 1, 1);
    send(1, 3'd0, 32'h10B, 32'h00000055, 0, 0, 32'h5522CC33, 1, 1);
    send(0, 3'd2, 32'h08, 0, 32'h5522CC33, 0, 0, 1, 1);
    send(0, 3'd2, 32'h06, 0, 0, 1, 0, 0, 1);
    drain();
    check("b2b_resp_count", n_resp - resp_before, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
